// File: rtl/multisim_arb_pkg.sv
// rtl/multisim_arb_pkg.sv - shared types and helpers for the multisim push/pull arbiters
package multisim_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Source-tag width for n requesters; a single requester still gets a 1-bit tag.
  function automatic int arb_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multisim_rr_pick.sv
// rtl/multisim_rr_pick.sv - combinational rotate-priority picker (first req at or above ptr, wrapping)
module multisim_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/multisim_server_push_arb.sv
// rtl/multisim_server_push_arb.sv - round-robin packet arbiter merging N_REQ push streams into one
module multisim_server_push_arb
  import multisim_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = arb_id_width(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    in_vld,
  output logic [N_REQ-1:0]                    in_rdy,
  input  logic [N_REQ-1:0]                    in_last,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    in_data,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic                                out_last,
  output logic [ID_WIDTH-1:0]                 out_id,
  output logic [DATA_WIDTH-1:0]               out_data
);

  arb_state_e          state, state_n;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_n;
  logic [ID_WIDTH-1:0] owner, owner_n;

  logic [N_REQ-1:0]    owner_mask;
  logic [N_REQ-1:0]    pick_req;
  logic [N_REQ-1:0]    gnt;
  logic [ID_WIDTH-1:0] win_idx;
  logic [ID_WIDTH-1:0] win_next;
  logic                load;
  logic                accept;

  // While locked only the owner competes, so the picker can only return the owner.
  assign owner_mask = N_REQ'(1) << owner;
  assign pick_req   = (state == ARB_LOCKED) ? (in_vld & owner_mask) : in_vld;

  multisim_rr_pick #(
    .N  (N_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win_idx)
  );

  assign load     = !out_vld || out_rdy;
  assign in_rdy   = gnt & {N_REQ{load && !rst}};
  assign accept   = load && (|gnt) && !rst;
  assign win_next = (win_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);

  // FSM state and round-robin bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      owner  <= owner_n;
    end
  end

  // Lock on a non-final beat; release and advance the pointer past the winner on a last beat.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    owner_n  = owner;
    if (accept) begin
      if (in_last[win_idx]) begin
        state_n  = ARB_IDLE;
        rr_ptr_n = win_next;
      end else begin
        state_n  = ARB_LOCKED;
        owner_n  = win_idx;
      end
    end
  end

  // Output register: load the accepted beat, or drain when the current beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_id   <= '0;
      out_data <= '0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_last <= in_last[win_idx];
      out_id   <= win_idx;
      out_data <= in_data[win_idx];
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multisim_server_push_arb.sv
// tb/tb_multisim_server_push_arb.sv - directed table-driven bench for multisim_server_push_arb
module tb_multisim_server_push_arb;

  logic             clk;
  logic             rst;
  logic [3:0]       in_vld;
  logic [3:0]       in_rdy;
  logic [3:0]       in_last;
  logic [3:0][63:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic             out_last;
  logic [1:0]       out_id;
  logic [63:0]      out_data;

  int checks = 0;
  int errors = 0;

  multisim_server_push_arb #(
    .N_REQ      (4),
    .DATA_WIDTH (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .out_id   (out_id),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ovld;
    logic [1:0] exp_id;
    logic       exp_olast;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int cnt[4];
    int exp_g;

    // fairness, packet lock, idle, owner bubble
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[7]  = '{4'b0111, 4'b0011, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{4'b0111, 4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[9]  = '{4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[10] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[17] = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};

    rst     = 1'b1;
    in_vld  = 4'b1111;
    in_last = 4'b1111;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 64'hD000 + 64'(i);

    #1;
    chk("reset in_rdy", 64'(in_rdy), 64'h0);
    chk("reset out_vld", 64'(out_vld), 64'h0);
    chk("reset out_last", 64'(out_last), 64'h0);
    chk("reset out_id", 64'(out_id), 64'h0);
    chk("reset out_data", out_data, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      in_vld  = tbl[k].vld;
      in_last = tbl[k].last;
      out_rdy = tbl[k].ordy;
      #1;
      chk($sformatf("vec%0d in_rdy", k), 64'(in_rdy), 64'(tbl[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_vld", k), 64'(out_vld), 64'(tbl[k].exp_ovld));
      if (tbl[k].exp_ovld) begin
        chk($sformatf("vec%0d out_id", k), 64'(out_id), 64'(tbl[k].exp_id));
        chk($sformatf("vec%0d out_last", k), 64'(out_last), 64'(tbl[k].exp_olast));
        chk($sformatf("vec%0d out_data", k), out_data, 64'hD000 + 64'(tbl[k].exp_id));
      end
    end

    // backpressure: park 0xA5 on the output, stall 5 cycles, then scoreboard the stream
    @(negedge clk);
    in_vld     = 4'b0001;
    in_last    = 4'b0001;
    in_data[0] = 64'hA5;
    out_rdy    = 1'b1;
    @(posedge clk);
    #1;
    chk("bp load out_data", out_data, 64'hA5);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    @(negedge clk);
    out_rdy = 1'b0;
    in_vld  = 4'b1111;
    in_last = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = {32'(i), 32'(cnt[i])};
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("bp%0d in_rdy", s), 64'(in_rdy), 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d out_vld", s), 64'(out_vld), 64'h1);
      chk($sformatf("bp%0d out_id", s), 64'(out_id), 64'h0);
      chk($sformatf("bp%0d out_data", s), out_data, 64'hA5);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    exp_g   = 1;
    for (int s = 0; s < 8; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sb%0d out_vld", s), 64'(out_vld), 64'h1);
      chk($sformatf("sb%0d out_id", s), 64'(out_id), 64'(exp_g));
      chk($sformatf("sb%0d out_data", s), out_data, {32'(exp_g), 32'(cnt[exp_g])});
      cnt[exp_g]++;
      in_data[exp_g] = {32'(exp_g), 32'(cnt[exp_g])};
      exp_g = (exp_g + 1) % 4;
    end

    // asynchronous reset mid-cycle with everyone requesting
    @(negedge clk);
    in_vld  = 4'b1111;
    in_last = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_vld", 64'(out_vld), 64'h0);
    chk("async rst in_rdy", 64'(in_rdy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst in_rdy", 64'(in_rdy), 64'h1);
    @(posedge clk);
    #1;
    chk("post rst out_vld", 64'(out_vld), 64'h1);
    chk("post rst out_id", 64'(out_id), 64'h0);

    // reset while locked on requester 1 abandons the lock
    @(negedge clk);
    in_vld  = 4'b0010;
    in_last = 4'b0000;
    #1;
    chk("lock1 in_rdy", 64'(in_rdy), 64'h2);
    @(negedge clk);
    in_vld = 4'b0000;
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    in_vld  = 4'b1000;
    in_last = 4'b1000;
    #1;
    chk("mid rst in_rdy", 64'(in_rdy), 64'h8);
    @(posedge clk);
    #1;
    chk("mid rst out_vld", 64'(out_vld), 64'h1);
    chk("mid rst out_id", 64'(out_id), 64'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multisim_server_push_arb.md
# multisim_server_push_arb

Round-robin arbiter that shares one multisim push channel between `N_REQ` requesters. It sits in front of `multisim_server_push`, which supports one server name per instance. The arbiter merges several producer streams into one. Each output beat carries a source tag (`out_id`) so the client side can demultiplex. Multi-beat packets are never interleaved: once a requester wins, it keeps the channel until it sends its `last` beat.

## Interface
- `N_REQ`, default 4: number of requesters, ≥1.
- `DATA_WIDTH`, default 64: payload width per beat.
- `ID_WIDTH`, default `N_REQ>1 ? $clog2(N_REQ) : 1`: width of the source tag. Derived; do not override.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_vld`  in  `N_REQ`  per-requester beat valid.
- `in_rdy`  out  `N_REQ`  per-requester beat accepted (combinational).
- `in_last`  in  `N_REQ`  beat is the final beat of its packet.
- `in_data`  in  `[N_REQ-1:0][DATA_WIDTH-1:0]`  per-requester payload.
- `out_vld`  out  1  output beat valid (registered).
- `out_rdy`  in  1  downstream ready; connects to `multisim_server_push.data_rdy`.
- `out_last`  out  1  registered copy of the winning `in_last`.
- `out_id`  out  `ID_WIDTH`  index of the requester that produced the beat.
- `out_data`  out  `DATA_WIDTH`  registered payload.

## Operation
- Output register: `out_vld`, `out_last`, `out_id`, `out_data`.
  - `load = !out_vld || out_rdy`.
  - `in_rdy[i] = load && grant[i] && !rst`.
  - At most one `in_rdy` bit is high in any cycle.
- FSM, two states:
  - **IDLE**
    - Grant goes to the first requester with `in_vld` set, searching upward from `rr_ptr` and wrapping modulo `N_REQ`.
    - No valid requester → no grant.
    - Accepted beat with `in_last=0` → LOCKED, `owner = winner`.
    - Accepted beat with `in_last=1` → stay in IDLE, `rr_ptr = (winner+1) mod N_REQ`.
  - **LOCKED**
    - Only `grant[owner]` can be set.
    - Other requesters are ignored, even if the owner deasserts `in_vld` mid-packet (the owner may bubble).
    - Accepted owner beat with `in_last=1` → IDLE, `rr_ptr = (owner+1) mod N_REQ`.
- `rr_ptr` wraps from `N_REQ-1` to 0.
- `N_REQ=1`: the arbiter degenerates to a one-stage pipeline register; `out_id` is always 0.
- Data is passed through unmodified. No reordering within a requester.

## Timing
- Reset values:
  - `out_vld=0`, `out_last=0`, `out_id=0`, `out_data=0`.
  - State IDLE, `rr_ptr=0`, `owner=0`.
  - All `in_rdy=0` while `rst` is high.
- Latency: a beat accepted at edge *k* appears on `out_*` after edge *k*, and is held until `out_vld && out_rdy`.
- Throughput: one beat per cycle when `out_rdy` is held high.
- Backpressure:
  - While `out_vld && !out_rdy`, all `out_*` outputs stay stable and all `in_rdy` are 0.
  - Requester inputs may change freely while not granted.
- Ready/valid rule: requesters must not drop `in_vld` or change `in_data`/`in_last` before acceptance. The arbiter does not check this.
- Simultaneous events: output consumed and new beat loaded on the same edge → no bubble.
- Reset mid-packet:
  - Outputs clear immediately (asynchronous).
  - The lock is abandoned. The partial packet is lost; the owner is responsible for restarting it.

## Structure
- Package `multisim_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e`.
  - Function `arb_id_width(n)`.
- Sub-module `multisim_rr_pick`: combinational. Takes `req[N]` and `ptr`, returns a one-hot `gnt` and an `idx`, using rotate-priority search. Reused by any later pull-side arbiter.
- Top-level RTL holds only the FSM, `rr_ptr`/`owner` registers and the output register.

## Test plan
- Reset:
  - Assert `rst` asynchronously, mid-cycle, with all `in_vld=1`.
  - `out_vld` goes to 0 without waiting for `clk`; `in_rdy=0000`.
  - After release, the first grant goes to requester 0.
- Fairness:
  - `N_REQ=4`, all requesters hold single-beat traffic (`in_last=1`), `out_rdy=1`.
  - `out_id` sequence is 0,1,2,3,0,1… with `out_vld` high every cycle.
- Packet lock:
  - Only requester 2 is valid and sends a 3-beat packet. Requesters 0 and 1 assert `in_vld` during beat 2.
  - `out_id` = 2,2,2,0,1; `out_last` = 0,0,1,1,1.
- Backpressure:
  - Hold `out_rdy=0` for 5 cycles while `out_vld=1`, `out_data=0xA5`.
  - Outputs stay stable, `in_rdy=0000`.
  - After release, the stream continues with no lost or duplicated beats (scoreboard per id).
- Owner bubble:
  - Requester 1 is locked and drops `in_vld` for 3 cycles while requester 3 is valid.
  - No grant to requester 3 until requester 1's `in_last` beat is accepted; then `out_id=3`.
- Reset mid-packet:
  - `rst` pulse while LOCKED on requester 1.
  - Afterwards, requester 3 alone valid → it is granted on the first cycle after reset release, with `out_id=3`.
